// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared types and sizing for the iterative multiply/divide sequencer.
// Holds the operation encoding, the FSM state encoding and the iteration counter width.
package muldiv_pkg;

    // M-extension operations handled by the sequencer
    typedef enum logic [1:0] {
        OP_MUL   = 2'b00,
        OP_MULHU = 2'b01,
        OP_DIVU  = 2'b10,
        OP_REMU  = 2'b11
    } muldiv_op_e;

    // Sequencer FSM states
    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_CALC = 2'b01,
        S_DONE = 2'b10
    } muldiv_state_e;

    // Counter must reach DATA_WIDTH-1, one spare bit keeps the compare simple
    function automatic int cnt_width(input int w);
        return $clog2(w) + 1;
    endfunction

    // Counter width for the default 32-bit datapath
    localparam int CNT_W = cnt_width(32);

endpackage

// File: rtl/muldiv_step.sv
// muldiv_step: one combinational iteration of the sequencer.
// Multiply: unsigned shift-add on a {high, low} product register, the multiplier
// sits in the low half and is consumed LSB first.
// Divide (only when MULDIV_SEQ_DIV_EN is defined): restoring shift-subtract, the
// partial remainder lives in the high half and the quotient is shifted into the low half.
module muldiv_step
    import muldiv_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic [2*DATA_WIDTH-1:0] acc_i,
    input  logic [DATA_WIDTH-1:0]   opnd_i,
    input  logic [1:0]              op_i,
    output logic [2*DATA_WIDTH-1:0] acc_o
);

    localparam int W = DATA_WIDTH;

    logic [W:0] mul_sum;

`ifdef MULDIV_SEQ_DIV_EN
    logic [W:0] rem_sh;
    logic [W:0] trial;
    logic       borrow;
`else
    logic       unused_op;
    assign unused_op = ^op_i;
`endif

    // Single iteration: add-and-shift for multiply, trial-subtract-and-shift for divide
    always_comb begin
        mul_sum = {1'b0, acc_i[2*W-1:W]} + (acc_i[0] ? {1'b0, opnd_i} : {(W+1){1'b0}});
        acc_o   = {mul_sum, acc_i[W-1:1]};
`ifdef MULDIV_SEQ_DIV_EN
        // Remainder stays below the divisor, so the W+1-bit difference is a
        // correctly signed value and its MSB is the borrow. A zero divisor never
        // borrows: the quotient fills with ones and the dividend bits end up in
        // the remainder, which is exactly the RISC-V divide-by-zero result.
        rem_sh = {acc_i[2*W-1:W], acc_i[W-1]};
        trial  = rem_sh - {1'b0, opnd_i};
        borrow = trial[W] & (|opnd_i);
        if (op_i[1]) begin
            acc_o = {(borrow ? rem_sh[W-1:0] : trial[W-1:0]), acc_i[W-2:0], ~borrow};
        end
`endif
    end

endmodule

// File: rtl/muldiv_seq.sv
// muldiv_seq: iterative MUL/MULHU/DIVU/REMU sequencer for the execute stage.
// One iteration per cycle over DATA_WIDTH cycles; stalls the pipeline until done.
// Build option MULDIV_SEQ_DIV_EN: when undefined the divide datapath is removed and
// DIVU/REMU complete on the next edge with a zero result.
module muldiv_seq
    import muldiv_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [1:0]            op,
    input  logic [DATA_WIDTH-1:0] op_a,
    input  logic [DATA_WIDTH-1:0] op_b,
    input  logic                  flush,
    output logic                  busy,
    output logic                  done,
    output logic [DATA_WIDTH-1:0] result,
    output logic                  stall
);

    localparam int W  = DATA_WIDTH;
    localparam int CW = cnt_width(DATA_WIDTH);

    muldiv_state_e     state_q, state_d;
    logic [CW-1:0]     count_q, count_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic [W-1:0]      result_q, result_d;

    muldiv_op_e        op_q;
    logic [W-1:0]      opnd_q;
    logic [2*W-1:0]    acc_q;
    logic [2*W-1:0]    step_acc;

    logic              accept;
    logic              last_step;

    assign accept    = start & ~flush & ((state_q == S_IDLE) | (state_q == S_DONE));
    assign last_step = (count_q == CW'(DATA_WIDTH - 1));

    assign stall  = (state_q == S_CALC) | accept;
    assign busy   = busy_q;
    assign done   = done_q;
    assign result = result_q;

    muldiv_step #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_step (
        .acc_i (acc_q),
        .opnd_i(opnd_q),
        .op_i  (op_q),
        .acc_o (step_acc)
    );

    // Next-state, counter and registered-output logic
    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        result_d = result_q;

        case (state_q)
            S_IDLE, S_DONE: begin
                state_d = S_IDLE;
                if (accept) begin
                    count_d = '0;
`ifdef MULDIV_SEQ_DIV_EN
                    state_d = S_CALC;
`else
                    // Without a divider, divide ops report a zero result straight away
                    if (op[1]) begin
                        state_d  = S_DONE;
                        result_d = '0;
                    end else begin
                        state_d = S_CALC;
                    end
`endif
                end
            end
            S_CALC: begin
                count_d = count_q + CW'(1);
                if (last_step) begin
                    state_d  = S_DONE;
                    result_d = ((op_q == OP_MULHU) || (op_q == OP_REMU)) ?
                               step_acc[2*W-1:W] : step_acc[W-1:0];
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Flush aborts everything; result keeps whatever it held before
        if (flush) begin
            state_d  = S_IDLE;
            result_d = result_q;
        end

        busy_d = (state_d == S_CALC);
        done_d = (state_d == S_DONE);
    end

    // Control state and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            count_q  <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            result_q <= result_d;
        end
    end

    // Operand capture at accept, one iteration per CALC cycle
    always_ff @(posedge clk) begin
        if (accept) begin
            op_q   <= muldiv_op_e'(op);
            opnd_q <= op[1] ? op_b : op_a;
            acc_q  <= {{W{1'b0}}, (op[1] ? op_a : op_b)};
        end else if (state_q == S_CALC) begin
            acc_q <= step_acc;
        end
    end

endmodule

// File: tb/tb_muldiv_seq.sv
// tb_muldiv_seq: scoreboard bench for muldiv_seq. Stimulus pushes expected results
// (value and completion cycle) computed with plain arithmetic; a monitor pops and
// compares on every done pulse.
module tb_muldiv_seq;

    localparam int W = 32;

`ifdef MULDIV_SEQ_DIV_EN
    localparam bit DIV_EN = 1'b1;
`else
    localparam bit DIV_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic [1:0]    op;
    logic [W-1:0]  op_a;
    logic [W-1:0]  op_b;
    logic          flush;
    logic          busy;
    logic          done;
    logic [W-1:0]  result;
    logic          stall;

    muldiv_seq #(.DATA_WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .op    (op),
        .op_a  (op_a),
        .op_b  (op_b),
        .flush (flush),
        .busy  (busy),
        .done  (done),
        .result(result),
        .stall (stall)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [W-1:0] res;
        int           due;
        string        name;
    } exp_t;

    exp_t         sb[$];
    int           n_pass = 0;
    int           n_tot  = 0;
    logic [W-1:0] last_res = '0;

    function automatic void check(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", nm, act, exp, cyc);
    endfunction

    // Reference model straight from the operation definitions
    function automatic logic [W-1:0] model(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
        logic [2*W-1:0] p;
        p = {{W{1'b0}}, a} * {{W{1'b0}}, b};
        case (o)
            2'b00:   return p[W-1:0];
            2'b01:   return p[2*W-1:W];
            2'b10:   return !DIV_EN ? '0 : (b == 0 ? {W{1'b1}} : a / b);
            default: return !DIV_EN ? '0 : (b == 0 ? a : a % b);
        endcase
    endfunction

    function automatic int lat(input logic [1:0] o);
        return (o[1] && !DIV_EN) ? 1 : W + 1;
    endfunction

    // Monitor: every done pulse must match the oldest outstanding expectation
    always @(negedge clk) begin
        if (rst_n && done) begin
            if (sb.size() == 0) begin
                check("spurious_done", 32'(done), 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check({e.name, "_result"}, result, e.res);
                check({e.name, "_latency"}, cyc, e.due);
                check({e.name, "_busy_in_done"}, 32'(busy), 32'd0);
                if (!start) check({e.name, "_stall_in_done"}, 32'(stall), 32'd0);
                last_res = e.res;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                         input string nm, input bit expect_done);
        exp_t e;
        start = 1'b1;
        op    = o;
        op_a  = a;
        op_b  = b;
        #1;
        check({nm, "_stall_accept"}, 32'(stall), 32'd1);
        if (expect_done) begin
            e.res  = model(o, a, b);
            e.due  = cyc + lat(o);
            e.name = nm;
            sb.push_back(e);
        end
        tick();
        start = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 120) begin
            tick();
            n++;
        end
        check("drain_outstanding", 32'(sb.size()), 32'd0);
        sb.delete();
        tick();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        int l;
        exp_t e;
        rst_n = 1'b0;
        start = 1'b0;
        flush = 1'b0;
        op    = 2'b00;
        op_a  = '0;
        op_b  = '0;

        repeat (3) @(posedge clk);
        #1;
        check("reset_busy",   32'(busy),  32'd0);
        check("reset_done",   32'(done),  32'd0);
        check("reset_result", result,     32'd0);
        check("reset_stall",  32'(stall), 32'd0);
        rst_n = 1'b1;
        tick();

        // MUL 7 x 6 with stall window
        k = cyc;
        issue(2'b00, 32'd7, 32'd6, "mul_7x6", 1'b1);
        repeat (31) tick();
        check("mul_7x6_cycle", cyc, k + 32);
        check("mul_7x6_stall_last_calc", 32'(stall), 32'd1);
        check("mul_7x6_busy_last_calc",  32'(busy),  32'd1);
        drain();

        issue(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "mulhu_max", 1'b1);
        drain();
        issue(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "mul_max", 1'b1);
        drain();

        // Back-to-back DIVU then REMU with start held high
        k = cyc;
        l = lat(2'b10);
        start = 1'b1;
        op    = 2'b10;
        op_a  = 32'd100;
        op_b  = 32'd7;
        e.res = model(2'b10, 32'd100, 32'd7); e.due = k + l; e.name = "b2b_divu";
        sb.push_back(e);
        tick();
        op = 2'b11;
        repeat (l - 1) tick();
        e.res = model(2'b11, 32'd100, 32'd7); e.due = k + 2 * l; e.name = "b2b_remu";
        sb.push_back(e);
        tick();
        start = 1'b0;
        drain();

        issue(2'b10, 32'd5, 32'd0, "divu_by0", 1'b1);
        drain();
        issue(2'b11, 32'd5, 32'd0, "remu_by0", 1'b1);
        drain();

        // Flush in the middle of a MUL
        issue(2'b00, 32'h1234, 32'h5678, "mul_flushed", 1'b0);
        repeat (9) tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("flush_busy",   32'(busy),  32'd0);
        check("flush_done",   32'(done),  32'd0);
        check("flush_result", result,     last_res);
        tick();
        issue(2'b00, 32'd3, 32'd3, "mul_3x3_after_flush", 1'b1);
        drain();

        // Flush and start together: nothing accepted
        start = 1'b1;
        flush = 1'b1;
        op    = 2'b00;
        op_a  = 32'd9;
        op_b  = 32'd9;
        #1;
        check("flush_start_stall", 32'(stall), 32'd0);
        tick();
        start = 1'b0;
        flush = 1'b0;
        check("flush_start_busy", 32'(busy), 32'd0);
        repeat (5) tick();

        // start during CALC must not re-capture operands
        issue(2'b00, 32'd11, 32'd13, "mul_ignore_restart", 1'b1);
        repeat (4) tick();
        start = 1'b1;
        op    = 2'b01;
        op_a  = 32'hFFFF_FFFF;
        op_b  = 32'hFFFF_FFFF;
        tick();
        start = 1'b0;
        drain();

        // Randomised operations against the model
        for (int i = 0; i < 24; i++) begin
            logic [1:0]   ro;
            logic [W-1:0] ra;
            logic [W-1:0] rb;
            ro = 2'($urandom_range(0, 3));
            ra = $urandom;
            rb = $urandom;
            if ($urandom_range(0, 3) == 0) rb = $urandom_range(1, 20);
            if ($urandom_range(0, 7) == 0) rb = '0;
            issue(ro, ra, rb, $sformatf("rand%0d_op%0d", i, ro), 1'b1);
            drain();
        end

        // Asynchronous reset during CALC
        issue(2'b00, 32'd9, 32'd9, "mul_reset", 1'b0);
        repeat (10) tick();
        rst_n = 1'b0;
        #1;
        check("async_rst_busy",   32'(busy), 32'd0);
        check("async_rst_done",   32'(done), 32'd0);
        check("async_rst_result", result,    32'd0);
        tick();
        rst_n = 1'b1;
        #1;
        check("post_rst_stall", 32'(stall), 32'd0);
        repeat (40) tick();
        check("post_rst_busy", 32'(busy), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule

// File: doc/muldiv_seq.md
# muldiv_seq

Iterative multiply/divide sequencer for the execute stage of the reduced RISC-V pipeline. It takes one M-extension operation (MUL, MULHU, DIVU, REMU), runs it over DATA_WIDTH cycles using shift-add or shift-subtract steps, and stalls the pipeline until the result is ready. It sits beside the main ALU and shares the same operand and result widths. The execute-stage mux selects its result when done is asserted.

## Interface
- DATA_WIDTH, 32, operand/result width; iteration count
- clk  in  1  rising-edge clock
- rst_n  in  1  reset, asynchronous assert, active-low
- start  in  1  request; sampled only in IDLE or DONE
- op  in  2  operation: 00 MUL (low word), 01 MULHU (high word, unsigned), 10 DIVU, 11 REMU
- op_a  in  DATA_WIDTH  multiplicand / dividend, captured at accept
- op_b  in  DATA_WIDTH  multiplier / divisor, captured at accept
- flush  in  1  pipeline flush; aborts any operation in flight
- busy  out  1  registered; high in CALC
- done  out  1  registered; one-cycle pulse, high only in DONE
- result  out  DATA_WIDTH  registered; valid while done=1, held until the next accept
- stall  out  1  combinational: (state==CALC) | (start & accept-able state & ~flush)

## Operation
- FSM states: IDLE, CALC, DONE.
- Accept: start=1, flush=0, and state IDLE or DONE. At that edge, capture op, op_a and op_b, clear the accumulator, clear count, and go to CALC. Back-to-back operations are allowed from DONE.
- CALC: perform one step per cycle and increment count (clog2(DATA_WIDTH)+1 bits). When count==DATA_WIDTH-1, the next edge goes to DONE and latches result.
- DONE: done=1 for exactly one cycle. Next state is CALC on accept, otherwise IDLE.
- Multiply: unsigned shift-add with a 2*DATA_WIDTH product register. MUL returns product[DATA_WIDTH-1:0]; MULHU returns product[2*DATA_WIDTH-1:DATA_WIDTH].
- Divide: restoring shift-subtract with a DATA_WIDTH+1-bit partial remainder. DIVU returns the quotient; REMU returns the remainder.
- Divide by zero (RISC-V rule): DIVU returns all ones and REMU returns op_a. Latency is unchanged.
- start during CALC is ignored; operands are not re-captured.
- flush in any state: next state is IDLE, done stays 0, and result keeps its old value. If flush and start arrive in the same cycle, flush wins and nothing is accepted.
- Reset mid-operation: the FSM returns to IDLE immediately and no done pulse is produced.
- Reset values: busy=0, done=0, result=0, state=IDLE, count=0.

## Timing
- Latency: done is high in the cycle following the edge that is DATA_WIDTH+1 edges after the accepting edge. For the default width this is 33 cycles after accept.
- stall is high from the accept cycle (combinational on start) through the last CALC cycle. It is low in DONE, so the instruction retires in the done cycle.
- Throughput: one operation every DATA_WIDTH+1 cycles when start is held high.
- busy falls on the same edge that done rises.

## Configuration
- MULDIV_SEQ_DIV_EN defined: DIVU and REMU are implemented as described above.
- MULDIV_SEQ_DIV_EN undefined: the divide datapath is removed.
  - op 10/11 is accepted and goes straight to DONE on the next edge, without entering CALC.
  - result=0 and done pulses once.
  - stall is high only in the accept cycle.
  - Multiply behaviour is unchanged.

## Structure
- Package muldiv_pkg holds:
  - the op enum (OP_MUL, OP_MULHU, OP_DIVU, OP_REMU),
  - the FSM state enum,
  - the localparam for the counter width.
- Sub-module muldiv_step is purely combinational. It computes one iteration (add-and-shift, or trial-subtract-and-shift) from the accumulator, the operands and the op. The top level owns the FSM, the counter and all registers.

## Test plan
- MUL 7 × 6: accept at cycle 0 → stall high for cycles 0–32, done at cycle 33, result=42.
- MULHU 0xFFFFFFFF × 0xFFFFFFFF → result=0xFFFFFFFE; MUL with the same operands → 0x00000001.
- DIVU 100 / 7 → 14; REMU 100 / 7 → 2. Run back-to-back with start held high: second done exactly 33 cycles after the first.
- DIVU 5 / 0 → 0xFFFFFFFF; REMU 5 / 0 → 5. Latency is 33 cycles. With MULDIV_SEQ_DIV_EN undefined: result=0, done at cycle 1.
- flush at cycle 10 of a MUL → busy low at cycle 11, no done pulse, result unchanged. A new MUL 3 × 3 accepted at cycle 12 → result 9.
- rst_n pulsed low mid-CALC → busy=0, done=0, result=0 asynchronously. stall low after release with start=0.
